depacketizer: RTL and testbench
===============================

Name: depacketizer

Overview:
Receive-side counterpart of the node packetizer. It accepts the 96-bit NoC packet as a stream of six 16-bit flits, MSB-first, and reassembles the AHB-style fields: source node, haddr[15:0], n_pkt, hsize, flags and hwdata. It presents them to the local slave/bridge logic through a valid/ready interface. It sits between the router's local ejection port and the node's AHB write bridge, and it flags framing, reserved-field and sequence errors.

Parameters:
NODE_ADDR, 16'h0000, this node's address; reported on errors only, with no filtering.
CHECK_SEQ, 1, when 1, enables the per-stream n_pkt sequence check.

Ports:
clk  in  1  single system clock; all logic is on the rising edge.
rstn  in  1  asynchronous, active-low reset.
flit_in  in  16  incoming flit data.
flit_sop  in  1  marks the first flit of a packet; qualified by flit_valid.
flit_valid  in  1  flit_in/flit_sop are valid.
flit_ready  out  1  block accepts a flit this cycle.
pkt_valid  out  1  reassembled packet available.
pkt_ready  in  1  consumer accepts the packet.
src_addr  out  16  flit 0.
haddr  out  16  flit 1.
n_pkt  out  16  flit 2.
hsize  out  3  flit 3 bits [10:8].
flags  out  8  flit 3 bits [7:0].
hwdata  out  32  {flit 4, flit 5}.
pkt_err  out  1  held with pkt_valid; set when flit 3 bits [15:11] are non-zero.
seq_err  out  1  held with pkt_valid; set on an n_pkt sequence mismatch.
frame_err  out  1  one-cycle pulse when a flit is dropped or a partial packet is discarded.

Behaviour:
- Reset (asynchronous on rstn low, released synchronously):
  - state = COLLECT, flit counter = 0, expected-sequence register = 0, seq_valid = 0.
  - All outputs are 0 except flit_ready, which is 1.
- A flit transfer occurs when flit_valid & flit_ready. A packet transfer occurs when pkt_valid & pkt_ready.
- States:
  - COLLECT: counter cnt runs 0..5.
  - HOLD: pkt_valid = 1 and output fields are stable.
- flit_ready = (state == COLLECT) | pkt_ready. In HOLD, a pop and the first flit of the next packet can occur in the same cycle.
- COLLECT, cnt == 0:
  - A flit with sop = 1 is stored as flit 0 and cnt becomes 1.
  - A flit with sop = 0 is dropped, frame_err pulses, and cnt stays 0.
- COLLECT, cnt in 1..4:
  - A flit with sop = 0 is stored at index cnt and cnt increments.
  - A flit with sop = 1 discards the partial packet, pulses frame_err, is stored as flit 0, and cnt becomes 1.
- COLLECT, cnt == 5:
  - A flit with sop = 0 is stored and the block moves to HOLD on the next cycle.
  - Fields, pkt_err and seq_err are registered in the same edge, so pkt_valid rises 1 cycle after the 6th flit transfer.
  - A flit with sop = 1 is handled as in the cnt 1..4 case.
- Latency: the 6th flit edge followed by 1 cycle gives pkt_valid. The minimum packet period is 6 cycles (full throughput).
- HOLD:
  - On pkt_ready without a concurrent flit, the block moves to COLLECT with cnt = 0 and pkt_valid falls.
  - On pkt_ready with a concurrent sop flit, the block moves to COLLECT with cnt = 1.
  - On pkt_ready with a concurrent non-sop flit, the flit is dropped and frame_err pulses.
  - Without pkt_ready, flit_ready = 0 and fields hold.
- Sequence check (CHECK_SEQ = 1):
  - The first accepted packet after reset sets seq_valid and never flags.
  - Otherwise seq_err = (n_pkt != expected).
  - expected is updated to n_pkt + 1 (mod 2^16) at completion of every packet, including erroneous ones. Wrap from 16'hFFFF to 0 is legal.
  - With CHECK_SEQ = 0, seq_err is always 0.
- Reset asserted mid-packet discards all partial state immediately.
- Output fields are don't-care-free: they hold their last value outside HOLD.

Decomposition:
- Shared package `noc_pkg`:
  - Constants: FLIT_W = 16, PKT_W = 96, N_FLITS = 6.
  - Field bit offsets: SRC_LSB 80, ADDR_LSB 64, NPKT_LSB 48, RSVD_LSB 43, HSIZE_LSB 40, FLAGS_LSB 32, DATA_LSB 0.
  - The packet field typedef.
- The packetizer is refactored to use the same package.
- No sub-module is needed: the 96-bit shift/assembly register, counter and FSM fit in one module.

Test Plan:
- Single packet:
  - Stimulus: flits 0x0003, 0x1234, 0x0000, 0x0205, 0xDEAD, 0xBEEF, sop on the first, pkt_ready = 1.
  - Response: 1 cycle later pkt_valid = 1, src 0x0003, haddr 0x1234, n_pkt 0, hsize 2, flags 0x05, hwdata 0xDEADBEEF, all errors 0.
- Back-pressure:
  - Stimulus: pkt_ready = 0 for 10 cycles after completion while the next sop flit is offered.
  - Response: flit_ready = 0 and fields stable; when pkt_ready rises, the pop and the next flit 0 transfer happen in the same cycle.
- Framing:
  - Stimulus: sop re-asserted at cnt 3.
  - Response: frame_err pulses once and the following 6-flit packet is delivered intact.
  - Stimulus: a non-sop flit at cnt 0.
  - Response: the flit is dropped with a frame_err pulse.
- Reserved/sequence:
  - Stimulus: flit 3 = 0x0802.
  - Response: pkt_err = 1.
  - Stimulus: packets with n_pkt 0xFFFE, 0xFFFF, 0x0000, 0x0005.
  - Response: seq_err asserts only on 0x0005.
- Reset:
  - Stimulus: rstn low after 4 flits, then a full packet.
  - Response: outputs clear immediately, no stale packet, the new packet is delivered correctly, and seq_err = 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC packet definitions: flit geometry, field offsets inside the
// 96-bit packet, and the unpacked field view used by the node endpoints.
package noc_pkg;

  localparam int FLIT_W  = 16;
  localparam int PKT_W   = 96;
  localparam int N_FLITS = 6;

  localparam int SRC_LSB   = 80;
  localparam int ADDR_LSB  = 64;
  localparam int NPKT_LSB  = 48;
  localparam int RSVD_LSB  = 43;
  localparam int HSIZE_LSB = 40;
  localparam int FLAGS_LSB = 32;
  localparam int DATA_LSB  = 0;

  // Field layout of one packet, MSB first, matching the wire order of flits.
  typedef struct packed {
    logic [FLIT_W-1:0]   src_addr;
    logic [FLIT_W-1:0]   haddr;
    logic [FLIT_W-1:0]   n_pkt;
    logic [4:0]          rsvd;
    logic [2:0]          hsize;
    logic [7:0]          flags;
    logic [2*FLIT_W-1:0] hwdata;
  } pkt_fields_t;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } depkt_state_t;

  // Split a raw 96-bit packet into its named fields.
  function automatic pkt_fields_t unpack_pkt(input logic [PKT_W-1:0] raw);
    pkt_fields_t f;
    f.src_addr = raw[SRC_LSB   +: FLIT_W];
    f.haddr    = raw[ADDR_LSB  +: FLIT_W];
    f.n_pkt    = raw[NPKT_LSB  +: FLIT_W];
    f.rsvd     = raw[RSVD_LSB  +: 5];
    f.hsize    = raw[HSIZE_LSB +: 3];
    f.flags    = raw[FLAGS_LSB +: 8];
    f.hwdata   = raw[DATA_LSB  +: 2*FLIT_W];
    return f;
  endfunction

endpackage

// File: rtl/depacketizer_if.sv
// Flit ingress and reassembled-packet egress of the depacketizer.
// The slave modport is the depacketizer's view; master is the surrounding
// router/bridge view.
interface depacketizer_if;
  import noc_pkg::*;

  logic [FLIT_W-1:0]   flit_in;
  logic                flit_sop;
  logic                flit_valid;
  logic                flit_ready;

  logic                pkt_valid;
  logic                pkt_ready;
  logic [FLIT_W-1:0]   src_addr;
  logic [FLIT_W-1:0]   haddr;
  logic [FLIT_W-1:0]   n_pkt;
  logic [2:0]          hsize;
  logic [7:0]          flags;
  logic [2*FLIT_W-1:0] hwdata;
  logic                pkt_err;
  logic                seq_err;
  logic                frame_err;
  logic [FLIT_W-1:0]   err_node;

  modport slave (
    input  flit_in, flit_sop, flit_valid, pkt_ready,
    output flit_ready, pkt_valid, src_addr, haddr, n_pkt, hsize, flags,
           hwdata, pkt_err, seq_err, frame_err, err_node
  );

  modport master (
    output flit_in, flit_sop, flit_valid, pkt_ready,
    input  flit_ready, pkt_valid, src_addr, haddr, n_pkt, hsize, flags,
           hwdata, pkt_err, seq_err, frame_err, err_node
  );

endinterface

// File: rtl/depacketizer.sv
// Reassembles six 16-bit flits (MSB first) into one NoC packet and presents
// the decoded AHB-style fields on a valid/ready port. Flags framing errors,
// non-zero reserved bits and n_pkt sequence gaps.
module depacketizer
  import noc_pkg::*;
#(
  parameter logic [15:0] NODE_ADDR = 16'h0000,
  parameter bit          CHECK_SEQ = 1'b1
) (
  input  logic           clk,
  input  logic           rstn,
  depacketizer_if.slave  bus
);

  // Flits 0..4 of the packet under assembly; the 6th is taken straight
  // from the input on the completing edge.
  localparam int ASM_W = PKT_W - FLIT_W;

  depkt_state_t        state;
  logic [2:0]          cnt;
  logic [ASM_W-1:0]    asm_reg;
  logic [FLIT_W-1:0]   seq_expected;
  logic                seq_valid;

  logic                pkt_valid_r;
  logic [FLIT_W-1:0]   src_addr_r;
  logic [FLIT_W-1:0]   haddr_r;
  logic [FLIT_W-1:0]   n_pkt_r;
  logic [2:0]          hsize_r;
  logic [7:0]          flags_r;
  logic [2*FLIT_W-1:0] hwdata_r;
  logic                pkt_err_r;
  logic                seq_err_r;
  logic                frame_err_r;

  pkt_fields_t         done_pkt;
  logic                last_flit;

  assign done_pkt  = unpack_pkt({asm_reg, bus.flit_in});
  assign last_flit = (cnt == 3'(N_FLITS - 1));

  assign bus.flit_ready = (state == ST_COLLECT) | bus.pkt_ready;
  assign bus.pkt_valid  = pkt_valid_r;
  assign bus.src_addr   = src_addr_r;
  assign bus.haddr      = haddr_r;
  assign bus.n_pkt      = n_pkt_r;
  assign bus.hsize      = hsize_r;
  assign bus.flags      = flags_r;
  assign bus.hwdata     = hwdata_r;
  assign bus.pkt_err    = pkt_err_r;
  assign bus.seq_err    = seq_err_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.err_node   = (pkt_err_r | seq_err_r | frame_err_r) ? NODE_ADDR : '0;

  // Collect/hold FSM with flit assembly, field registers and sequence check.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_COLLECT;
      cnt          <= '0;
      asm_reg      <= '0;
      seq_expected <= '0;
      seq_valid    <= 1'b0;
      pkt_valid_r  <= 1'b0;
      src_addr_r   <= '0;
      haddr_r      <= '0;
      n_pkt_r      <= '0;
      hsize_r      <= '0;
      flags_r      <= '0;
      hwdata_r     <= '0;
      pkt_err_r    <= 1'b0;
      seq_err_r    <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      case (state)
        ST_COLLECT: begin
          if (bus.flit_valid) begin
            if (bus.flit_sop) begin
              if (cnt != 3'd0) frame_err_r <= 1'b1;
              asm_reg <= {{(ASM_W - FLIT_W){1'b0}}, bus.flit_in};
              cnt     <= 3'd1;
            end else if (cnt == 3'd0) begin
              frame_err_r <= 1'b1;
            end else if (last_flit) begin
              src_addr_r   <= done_pkt.src_addr;
              haddr_r      <= done_pkt.haddr;
              n_pkt_r      <= done_pkt.n_pkt;
              hsize_r      <= done_pkt.hsize;
              flags_r      <= done_pkt.flags;
              hwdata_r     <= done_pkt.hwdata;
              pkt_err_r    <= |done_pkt.rsvd;
              seq_err_r    <= CHECK_SEQ && seq_valid &&
                              (done_pkt.n_pkt != seq_expected);
              seq_expected <= done_pkt.n_pkt + 16'd1;
              seq_valid    <= 1'b1;
              pkt_valid_r  <= 1'b1;
              cnt          <= '0;
              state        <= ST_HOLD;
            end else begin
              asm_reg <= {asm_reg[ASM_W-FLIT_W-1:0], bus.flit_in};
              cnt     <= cnt + 3'd1;
            end
          end
        end
        ST_HOLD: begin
          if (bus.pkt_ready) begin
            pkt_valid_r <= 1'b0;
            pkt_err_r   <= 1'b0;
            seq_err_r   <= 1'b0;
            state       <= ST_COLLECT;
            cnt         <= '0;
            if (bus.flit_valid) begin
              if (bus.flit_sop) begin
                asm_reg <= {{(ASM_W - FLIT_W){1'b0}}, bus.flit_in};
                cnt     <= 3'd1;
              end else begin
                frame_err_r <= 1'b1;
              end
            end
          end
        end
        default: begin
          state <= ST_COLLECT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_depacketizer.sv
// Directed plus randomized bench for the depacketizer, checked against a
// field-level reference model of the packet format and sequence rule.
module tb_depacketizer;
  import noc_pkg::*;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  depacketizer_if bus ();

  depacketizer #(
    .NODE_ADDR(16'h0000),
    .CHECK_SEQ(1'b1)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int          tests_run    = 0;
  int          tests_failed = 0;
  bit          model_seen   = 1'b0;
  logic [15:0] model_next   = 16'h0000;

  // One comparison point.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one flit and wait (bounded) until it is accepted on a rising edge.
  task automatic send_flit(input logic [15:0] d, input logic sop);
    int waited = 0;
    bus.flit_in    = d;
    bus.flit_sop   = sop;
    bus.flit_valid = 1'b1;
    while (bus.flit_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) check("flit_ready_timeout", {31'b0, bus.flit_ready}, 32'd1);
    @(posedge clk); #1;
    bus.flit_valid = 1'b0;
    bus.flit_sop   = 1'b0;
  endtask

  // Reference model: decode fields arithmetically and apply the sequence rule.
  task automatic check_pkt(input string tag, input logic [95:0] p);
    logic [15:0] f [6];
    logic [15:0] e_n;
    logic [31:0] e_data;
    logic        e_perr, e_serr;
    for (int i = 0; i < 6; i++) f[i] = p[95 - 16*i -: 16];
    e_n    = f[2];
    e_data = (32'(f[4]) << 16) | 32'(f[5]);
    e_perr = (f[3] >> 11) != 16'd0;
    e_serr = model_seen && (e_n != model_next);
    model_next = e_n + 16'd1;
    model_seen = 1'b1;
    check($sformatf("%s.valid", tag), bus.pkt_valid, 1);
    check($sformatf("%s.src", tag), bus.src_addr, f[0]);
    check($sformatf("%s.haddr", tag), bus.haddr, f[1]);
    check($sformatf("%s.n_pkt", tag), bus.n_pkt, e_n);
    check($sformatf("%s.hsize", tag), bus.hsize, (f[3] >> 8) % 8);
    check($sformatf("%s.flags", tag), bus.flags, f[3] % 256);
    check($sformatf("%s.hwdata", tag), bus.hwdata, e_data);
    check($sformatf("%s.pkt_err", tag), bus.pkt_err, e_perr);
    check($sformatf("%s.seq_err", tag), bus.seq_err, e_serr);
  endtask

  // Send flits first..5 of packet p (sop on flit 0) and check the result.
  task automatic send_packet(input string tag, input logic [95:0] p, input int first);
    for (int i = first; i < 6; i++) begin
      send_flit(p[95 - 16*i -: 16], i == 0);
      check($sformatf("%s.frame_err%0d", tag, i), bus.frame_err, 0);
      if (i == 4) check($sformatf("%s.early_valid", tag), bus.pkt_valid, 0);
    end
    check_pkt(tag, p);
  endtask

  logic [95:0] rp;
  logic [15:0] rf [6];
  bit          stall;
  int          hold;

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence followed by randomized packets.
  initial begin
    rstn           = 1'b0;
    bus.flit_in    = '0;
    bus.flit_sop   = 1'b0;
    bus.flit_valid = 1'b0;
    bus.pkt_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.pkt_valid", bus.pkt_valid, 0);
    check("rst.flit_ready", bus.flit_ready, 1);
    check("rst.frame_err", bus.frame_err, 0);
    check("rst.pkt_err", bus.pkt_err, 0);
    check("rst.seq_err", bus.seq_err, 0);
    check("rst.src", bus.src_addr, 0);
    check("rst.hwdata", bus.hwdata, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single packet");
    send_packet("single", 96'h0003_1234_0000_0205_DEAD_BEEF, 0);
    check("single.hwdata_const", bus.hwdata, 32'hDEADBEEF);
    check("single.hsize_const", bus.hsize, 2);
    @(posedge clk); #1;
    check("single.popped", bus.pkt_valid, 0);

    $display("[TB] back-pressure");
    bus.pkt_ready = 1'b0;
    send_packet("bp_a", 96'h0003_1000_0001_0103_1111_2222, 0);
    bus.flit_in    = 16'h0007;
    bus.flit_sop   = 1'b1;
    bus.flit_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp.flit_ready", bus.flit_ready, 0);
      check("bp.pkt_valid", bus.pkt_valid, 1);
      check("bp.hwdata_stable", bus.hwdata, 32'h1111_2222);
    end
    bus.pkt_ready = 1'b1;
    #1;
    check("bp.flit_ready_rise", bus.flit_ready, 1);
    @(posedge clk); #1;
    bus.flit_valid = 1'b0;
    bus.flit_sop   = 1'b0;
    check("bp.pop", bus.pkt_valid, 0);
    check("bp.pop_frame_err", bus.frame_err, 0);
    send_packet("bp_b", 96'h0007_2000_0002_0301_CAFE_F00D, 1);

    $display("[TB] framing: sop restart at cnt 3");
    send_flit(16'h0009, 1'b1);
    send_flit(16'h3000, 1'b0);
    send_flit(16'h0099, 1'b0);
    send_flit(16'h000A, 1'b1);
    check("restart.frame_err", bus.frame_err, 1);
    send_packet("restart", 96'h000A_4000_0003_0107_0102_0304, 1);

    $display("[TB] framing: non-sop flit at cnt 0");
    @(posedge clk); #1;
    send_flit(16'h5555, 1'b0);
    check("drop.frame_err", bus.frame_err, 1);
    check("drop.pkt_valid", bus.pkt_valid, 0);
    @(posedge clk); #1;
    check("drop.frame_err_pulse", bus.frame_err, 0);
    send_packet("after_drop", 96'h000B_5000_0004_0011_AAAA_5555, 0);

    $display("[TB] reserved bits");
    send_packet("rsvd", 96'h000C_6000_0005_0802_0000_0001, 0);
    check("rsvd.pkt_err_const", bus.pkt_err, 1);

    $display("[TB] sequence wrap");
    send_packet("seq_fffd", 96'h000D_7000_FFFD_0000_0000_0002, 0);
    send_packet("seq_fffe", 96'h000D_7000_FFFE_0000_0000_0003, 0);
    send_packet("seq_ffff", 96'h000D_7000_FFFF_0000_0000_0004, 0);
    send_packet("seq_0000", 96'h000D_7000_0000_0000_0000_0005, 0);
    send_packet("seq_0005", 96'h000D_7000_0005_0000_0000_0006, 0);
    check("seq_0005.seq_err_const", bus.seq_err, 1);

    $display("[TB] reset mid-packet");
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send_flit(16'h0E00 + 16'(i), i == 0);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst.pkt_valid", bus.pkt_valid, 0);
    check("midrst.src", bus.src_addr, 0);
    check("midrst.hwdata", bus.hwdata, 0);
    check("midrst.flit_ready", bus.flit_ready, 1);
    model_seen = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    send_packet("post_rst", 96'h000F_8000_1234_0204_7654_3210, 0);
    check("post_rst.seq_err_const", bus.seq_err, 0);
    @(posedge clk); #1;

    $display("[TB] randomized packets");
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 6; i++) rf[i] = 16'($urandom);
      rf[2] = ($urandom_range(0, 3) != 0) ? model_next : 16'($urandom);
      rf[3] = {(($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0),
               3'($urandom), 8'($urandom)};
      rp = {rf[0], rf[1], rf[2], rf[3], rf[4], rf[5]};
      stall = 1'($urandom_range(0, 1));
      bus.pkt_ready = !stall;
      send_packet($sformatf("rnd%0d", k), rp, 0);
      if (stall) begin
        hold = $urandom_range(1, 4);
        repeat (hold) begin
          @(posedge clk); #1;
          check($sformatf("rnd%0d.hold_ready", k), bus.flit_ready, 0);
          check($sformatf("rnd%0d.hold_data", k), bus.hwdata, rp[31:0]);
        end
        bus.pkt_ready = 1'b1;
      end
      @(posedge clk); #1;
      check($sformatf("rnd%0d.pop", k), bus.pkt_valid, 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
